// File: rtl/sram_ctrl_pkg.sv
// Shared widths and request record for the SRAM port controller.
// The struct field widths follow the default macro geometry.
package sram_ctrl_pkg;

  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 32;
  localparam int WMASK_W    = 4;
  localparam int STARVE_LIM = 3;

  typedef struct packed {
    logic               we;
    logic [WMASK_W-1:0] wmask;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
  } sram_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. cand_o is the pre-suppress winner so the caller
// can inspect it; a suppressed cycle grants nothing and leaves the pointer alone.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstb,
  input  logic [1:0] req_i,
  input  logic       suppress_i,
  output logic [1:0] cand_o,
  output logic [1:0] gnt_o
);

  logic rr_q, rr_d;

  always_comb begin
    cand_o = req_i;
    if (req_i == 2'b11) cand_o = rr_q ? 2'b10 : 2'b01;
    gnt_o = suppress_i ? 2'b00 : cand_o;
    rr_d  = rr_q;
    // pointer moves to whoever lost
    if (gnt_o[0])      rr_d = 1'b1;
    else if (gnt_o[1]) rr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstb) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/sram_port_ctrl.sv
// Shares a 1RW+1R SRAM macro: requesters 0/1 round-robin on the RW port,
// requester 2 on the R port, with same-address collision blocking and bounded starvation.
module sram_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_W,
  parameter int DATA_WIDTH   = DATA_W,
  parameter int NUM_WMASKS   = WMASK_W,
  parameter int STARVE_LIMIT = STARVE_LIM
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  rq0_valid,
  output logic                  rq0_ready,
  input  logic                  rq0_we,
  input  logic [NUM_WMASKS-1:0] rq0_wmask,
  input  logic [ADDR_WIDTH-1:0] rq0_addr,
  input  logic [DATA_WIDTH-1:0] rq0_wdata,
  output logic                  rq0_rvalid,
  output logic [DATA_WIDTH-1:0] rq0_rdata,
  input  logic                  rq1_valid,
  output logic                  rq1_ready,
  input  logic                  rq1_we,
  input  logic [NUM_WMASKS-1:0] rq1_wmask,
  input  logic [ADDR_WIDTH-1:0] rq1_addr,
  input  logic [DATA_WIDTH-1:0] rq1_wdata,
  output logic                  rq1_rvalid,
  output logic [DATA_WIDTH-1:0] rq1_rdata,
  input  logic                  rq2_valid,
  output logic                  rq2_ready,
  input  logic [ADDR_WIDTH-1:0] rq2_addr,
  output logic                  rq2_rvalid,
  output logic [DATA_WIDTH-1:0] rq2_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  sram_req_t       req0, req1, req_c;
  logic [1:0]      cand, gnt;
  logic            collide, starve_full, suppress, rq2_acc;
  logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            rsp0_vld_q, rsp0_vld_d, rsp0_own_q, rsp0_own_d;
  logic            rsp2_vld_q, rsp2_vld_d;

  assign req0 = '{we: rq0_we, wmask: rq0_wmask, addr: rq0_addr, wdata: rq0_wdata};
  assign req1 = '{we: rq1_we, wmask: rq1_wmask, addr: rq1_addr, wdata: rq1_wdata};

  rr_arb2 u_arb (
    .clk        (clk),
    .rstb       (rstb),
    .req_i      ({rq1_valid, rq0_valid} & {2{rstb}}),
    .suppress_i (suppress),
    .cand_o     (cand),
    .gnt_o      (gnt)
  );

  // a write and an R-port read of the same word in one cycle would race inside the macro
  assign req_c       = cand[1] ? req1 : req0;
  assign collide     = (|cand) & req_c.we & rq2_valid & (rq2_addr == req_c.addr);
  assign starve_full = (starve_cnt_q == SW'(STARVE_LIMIT));
  assign suppress    = collide & starve_full;
  assign rq2_acc     = rstb & rq2_valid & ~(collide & ~starve_full);

  assign rq0_ready  = gnt[0];
  assign rq1_ready  = gnt[1];
  assign rq2_ready  = rq2_acc;
  assign sram_csb1  = ~rq2_acc;
  assign sram_addr1 = rq2_addr;

  always_comb begin
    sram_csb0   = 1'b1;
    sram_web0   = 1'b0;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    if (|gnt) begin
      sram_csb0   = 1'b0;
      sram_web0   = ~req_c.we;
      sram_wmask0 = req_c.wmask;
      sram_addr0  = req_c.addr;
      sram_din0   = req_c.wdata;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (rq2_acc || !rq2_valid) starve_cnt_d = '0;
    else if (collide)          starve_cnt_d = starve_cnt_q + SW'(1);
    rsp0_vld_d = (|gnt) & ~req_c.we;
    rsp0_own_d = gnt[1];
    rsp2_vld_d = rq2_acc;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      starve_cnt_q <= '0;
      rsp0_vld_q   <= 1'b0;
      rsp0_own_q   <= 1'b0;
      rsp2_vld_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rsp0_vld_q   <= rsp0_vld_d;
      rsp0_own_q   <= rsp0_own_d;
      rsp2_vld_q   <= rsp2_vld_d;
    end
  end

  // gating with rstb drops a read accepted just before reset took hold
  assign rq0_rvalid = rstb & rsp0_vld_q & ~rsp0_own_q;
  assign rq1_rvalid = rstb & rsp0_vld_q & rsp0_own_q;
  assign rq2_rvalid = rstb & rsp2_vld_q;
  assign rq0_rdata  = rq0_rvalid ? sram_dout0 : '0;
  assign rq1_rdata  = rq1_rvalid ? sram_dout0 : '0;
  assign rq2_rdata  = rq2_rvalid ? sram_dout1 : '0;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: behavioural macro, reference model of the sharing
// rules, a directed vector table, a starvation sequence and a random run.
module tb_sram_port_ctrl;

  localparam int LIM = 3;

  logic        clk;
  logic        rstb;
  logic        rq0_valid, rq0_ready, rq0_we, rq0_rvalid;
  logic [3:0]  rq0_wmask;
  logic [8:0]  rq0_addr;
  logic [31:0] rq0_wdata, rq0_rdata;
  logic        rq1_valid, rq1_ready, rq1_we, rq1_rvalid;
  logic [3:0]  rq1_wmask;
  logic [8:0]  rq1_addr;
  logic [31:0] rq1_wdata, rq1_rdata;
  logic        rq2_valid, rq2_ready, rq2_rvalid;
  logic [8:0]  rq2_addr;
  logic [31:0] rq2_rdata;
  logic        sram_csb0, sram_web0, sram_csb1;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0, sram_addr1;
  logic [31:0] sram_din0, sram_dout0, sram_dout1;

  sram_port_ctrl dut (
    .clk(clk), .rstb(rstb),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_we(rq0_we), .rq0_wmask(rq0_wmask),
    .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata), .rq0_rvalid(rq0_rvalid), .rq0_rdata(rq0_rdata),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_we(rq1_we), .rq1_wmask(rq1_wmask),
    .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata), .rq1_rvalid(rq1_rvalid), .rq1_rdata(rq1_rdata),
    .rq2_valid(rq2_valid), .rq2_ready(rq2_ready), .rq2_addr(rq2_addr),
    .rq2_rvalid(rq2_rvalid), .rq2_rdata(rq2_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [8:0] a);
    return 32'h5A5A0000 | {23'd0, a};
  endfunction

  // Macro model: commands sampled at posedge, executed at the following negedge,
  // dout is garbage from each posedge until the next read lands.
  logic [31:0] mem [512];
  logic        m0_en, m0_we, m1_en;
  logic [3:0]  m0_mask;
  logic [8:0]  m0_addr, m1_addr;
  logic [31:0] m0_din;

  always @(posedge clk or negedge clk) begin
    if (clk) begin
      m0_en <= !sram_csb0; m0_we <= !sram_web0; m0_mask <= sram_wmask0;
      m0_addr <= sram_addr0; m0_din <= sram_din0;
      m1_en <= !sram_csb1; m1_addr <= sram_addr1;
      sram_dout0 <= $urandom; sram_dout1 <= $urandom;
    end else begin
      if (m0_en && m0_we)
        for (int b = 0; b < 4; b++)
          if (m0_mask[b]) mem[m0_addr][8*b +: 8] = m0_din[8*b +: 8];
      if (m0_en && !m0_we) sram_dout0 <= mem[m0_addr];
      if (m1_en)           sram_dout1 <= mem[m1_addr];
    end
  end

  typedef struct packed {
    logic        rstb;
    logic        v0, we0; logic [8:0] a0; logic [31:0] d0; logic [3:0] m0;
    logic        v1, we1; logic [8:0] a1; logic [31:0] d1; logic [3:0] m1;
    logic        v2;      logic [8:0] a2;
    logic [2:0]  e_rdy;
    logic        e_csb0, e_web0; logic [8:0] e_addr0; logic e_csb1;
    logic [2:0]  e_rv;
    logic        e_chkd; logic [31:0] e_rdor;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state
  logic [31:0] mem_ref [512];
  int          m_rr, m_starve;
  logic [2:0]  m_pv;
  logic [31:0] m_pd [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic v0, input logic we0, input logic [8:0] a0,
                              input logic [31:0] d0, input logic [3:0] m0,
                              input logic v1, input logic [8:0] a1, input logic v2, input logic [8:0] a2,
                              input logic [2:0] rdy, input logic csb0, input logic web0,
                              input logic [8:0] ad0, input logic csb1,
                              input logic [2:0] rv, input logic chkd, input logic [31:0] rdor);
    vec_t v;
    v = '{rstb: r, v0: v0, we0: we0, a0: a0, d0: d0, m0: m0,
          v1: v1, we1: 1'b0, a1: a1, d1: 32'd0, m1: 4'hF, v2: v2, a2: a2,
          e_rdy: rdy, e_csb0: csb0, e_web0: web0, e_addr0: ad0, e_csb1: csb1,
          e_rv: rv, e_chkd: chkd, e_rdor: rdor};
    return v;
  endfunction

  // Drive at posedge+1, check at posedge+8 (macro read data has landed), then advance.
  task automatic run_cycle(input vec_t v, input logic tbl, output logic [2:0] rdy_seen);
    int          cand, gnt;
    logic        acc2, coll, cwe;
    logic [8:0]  cad;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic [2:0]  rv_exp;
    rstb = v.rstb;
    rq0_valid = v.v0; rq0_we = v.we0; rq0_addr = v.a0; rq0_wdata = v.d0; rq0_wmask = v.m0;
    rq1_valid = v.v1; rq1_we = v.we1; rq1_addr = v.a1; rq1_wdata = v.d1; rq1_wmask = v.m1;
    rq2_valid = v.v2; rq2_addr = v.a2;
    #7;
    cand = -1;
    if (v.rstb) begin
      if (v.v0 && v.v1) cand = m_rr;
      else if (v.v0)    cand = 0;
      else if (v.v1)    cand = 1;
    end
    cwe  = (cand == 0) ? v.we0 : v.we1;
    cad  = (cand == 0) ? v.a0  : v.a1;
    coll = (cand >= 0) && cwe && v.v2 && (v.a2 == cad);
    gnt  = (coll && m_starve == LIM) ? -1 : cand;
    acc2 = v.rstb && v.v2 && !(coll && m_starve < LIM);

    rdy_seen = {rq2_ready, rq1_ready, rq0_ready};
    chk("ready", 32'(rdy_seen), 32'({acc2, gnt == 1, gnt == 0}));
    rv_exp = v.rstb ? m_pv : 3'b000;
    chk("rvalid", 32'({rq2_rvalid, rq1_rvalid, rq0_rvalid}), 32'(rv_exp));
    chk("rdata0", rq0_rdata, rv_exp[0] ? m_pd[0] : 32'd0);
    chk("rdata1", rq1_rdata, rv_exp[1] ? m_pd[1] : 32'd0);
    chk("rdata2", rq2_rdata, rv_exp[2] ? m_pd[2] : 32'd0);
    if (tbl) begin
      chk("tbl_ready", 32'(rdy_seen), 32'(v.e_rdy));
      chk("tbl_csb0", 32'(sram_csb0), 32'(v.e_csb0));
      chk("tbl_web0", 32'(sram_web0), 32'(v.e_web0));
      chk("tbl_addr0", 32'(sram_addr0), 32'(v.e_addr0));
      chk("tbl_csb1", 32'(sram_csb1), 32'(v.e_csb1));
      chk("tbl_rvalid", 32'({rq2_rvalid, rq1_rvalid, rq0_rvalid}), 32'(v.e_rv));
      if (v.e_chkd) chk("tbl_rdata", rq0_rdata | rq1_rdata | rq2_rdata, v.e_rdor);
    end

    m_pv = 3'b000;
    if (!v.rstb) begin
      m_rr = 0; m_starve = 0;
    end else begin
      if (gnt >= 0 && !cwe) begin m_pv[gnt] = 1'b1; m_pd[gnt] = mem_ref[cad]; end
      if (acc2)             begin m_pv[2]   = 1'b1; m_pd[2]   = mem_ref[v.a2]; end
      if (gnt >= 0 && cwe) begin
        wd = (gnt == 0) ? v.d0 : v.d1;
        wm = (gnt == 0) ? v.m0 : v.m1;
        for (int b = 0; b < 4; b++)
          if (wm[b]) mem_ref[cad][8*b +: 8] = wd[8*b +: 8];
      end
      if (acc2 || !v.v2) m_starve = 0;
      else if (coll)     m_starve = m_starve + 1;
      if (gnt >= 0) m_rr = 1 - gnt;
    end
    @(posedge clk); #1;
  endtask

  localparam logic [8:0] A = 9'h010, B = 9'h020, C = 9'h030;

  initial begin
    vec_t       tbl [21];
    vec_t       v;
    logic [2:0] rdy;
    logic [7:0] seq_r0, seq_r1, seq_r2;

    for (int i = 0; i < 512; i++) begin
      mem[i]     = init_val(9'(i));
      mem_ref[i] = init_val(9'(i));
    end
    m_rr = 0; m_starve = 0; m_pv = 3'b000;
    m_pd[0] = '0; m_pd[1] = '0; m_pd[2] = '0;
    rstb = 1'b0;
    rq0_valid = 0; rq0_we = 0; rq0_addr = '0; rq0_wdata = '0; rq0_wmask = '0;
    rq1_valid = 0; rq1_we = 0; rq1_addr = '0; rq1_wdata = '0; rq1_wmask = '0;
    rq2_valid = 0; rq2_addr = '0;

    //          r  v0 we a0      d0            m0    v1 a1      v2 a2     rdy    c0 w0 ad0     c1 rv     ck rdor
    tbl[0]  = mk(0, 1, 0, A,      32'h0,        4'hF, 1, B,      1, C,     3'b000, 1, 0, 9'h000, 1, 3'b000, 0, 32'h0);
    tbl[1]  = mk(0, 1, 0, A,      32'h0,        4'hF, 1, B,      1, C,     3'b000, 1, 0, 9'h000, 1, 3'b000, 0, 32'h0);
    tbl[2]  = mk(0, 1, 0, A,      32'h0,        4'hF, 1, B,      1, C,     3'b000, 1, 0, 9'h000, 1, 3'b000, 0, 32'h0);
    tbl[3]  = mk(1, 1, 0, A,      32'h0,        4'hF, 1, B,      1, C,     3'b101, 0, 1, A,      0, 3'b000, 0, 32'h0);
    tbl[4]  = mk(1, 1, 0, A,      32'h0,        4'hF, 1, B,      1, C,     3'b110, 0, 1, B,      0, 3'b101, 0, 32'h0);
    tbl[5]  = mk(1, 1, 0, A,      32'h0,        4'hF, 1, B,      1, C,     3'b101, 0, 1, A,      0, 3'b110, 0, 32'h0);
    tbl[6]  = mk(1, 1, 0, A,      32'h0,        4'hF, 1, B,      1, C,     3'b110, 0, 1, B,      0, 3'b101, 0, 32'h0);
    tbl[7]  = mk(1, 1, 1, 9'h1FF, 32'h11223344, 4'hF, 0, 9'h000, 0, 9'h000, 3'b001, 0, 0, 9'h1FF, 1, 3'b110, 0, 32'h0);
    tbl[8]  = mk(1, 1, 1, 9'h1FF, 32'hAABBCCDD, 4'h5, 0, 9'h000, 0, 9'h000, 3'b001, 0, 0, 9'h1FF, 1, 3'b000, 0, 32'h0);
    tbl[9]  = mk(1, 0, 0, 9'h000, 32'h0,        4'hF, 1, 9'h1FF, 0, 9'h000, 3'b010, 0, 1, 9'h1FF, 1, 3'b000, 0, 32'h0);
    tbl[10] = mk(1, 1, 1, 9'h005, 32'hCAFE0001, 4'hF, 0, 9'h000, 1, 9'h005, 3'b001, 0, 0, 9'h005, 1, 3'b010, 1, 32'h11BB33DD);
    tbl[11] = mk(1, 1, 1, 9'h005, 32'hCAFE0001, 4'hF, 0, 9'h000, 1, 9'h005, 3'b001, 0, 0, 9'h005, 1, 3'b000, 0, 32'h0);
    tbl[12] = mk(1, 1, 1, 9'h005, 32'hCAFE0001, 4'hF, 0, 9'h000, 1, 9'h005, 3'b001, 0, 0, 9'h005, 1, 3'b000, 0, 32'h0);
    tbl[13] = mk(1, 1, 1, 9'h005, 32'hCAFE0001, 4'hF, 0, 9'h000, 1, 9'h005, 3'b100, 1, 0, 9'h000, 0, 3'b000, 0, 32'h0);
    tbl[14] = mk(1, 1, 1, 9'h0A0, 32'hDEADBEEF, 4'hF, 0, 9'h000, 0, 9'h000, 3'b001, 0, 0, 9'h0A0, 1, 3'b100, 1, 32'hCAFE0001);
    tbl[15] = mk(1, 0, 0, 9'h000, 32'h0,        4'hF, 0, 9'h000, 1, 9'h0A0, 3'b100, 1, 0, 9'h000, 0, 3'b000, 0, 32'h0);
    tbl[16] = mk(1, 0, 0, 9'h000, 32'h0,        4'hF, 0, 9'h000, 0, 9'h000, 3'b000, 1, 0, 9'h000, 1, 3'b100, 1, 32'hDEADBEEF);
    tbl[17] = mk(1, 0, 0, 9'h000, 32'h0,        4'hF, 1, B,      0, 9'h000, 3'b010, 0, 1, B,      1, 3'b000, 0, 32'h0);
    tbl[18] = mk(0, 0, 0, 9'h000, 32'h0,        4'hF, 0, 9'h000, 0, 9'h000, 3'b000, 1, 0, 9'h000, 1, 3'b000, 0, 32'h0);
    tbl[19] = mk(1, 0, 0, 9'h000, 32'h0,        4'hF, 0, 9'h000, 0, 9'h000, 3'b000, 1, 0, 9'h000, 1, 3'b000, 0, 32'h0);
    tbl[20] = mk(1, 1, 0, A,      32'h0,        4'hF, 1, B,      0, 9'h000, 3'b001, 0, 1, A,      1, 3'b000, 0, 32'h0);

    @(posedge clk); #1;
    for (int i = 0; i < 21; i++) run_cycle(tbl[i], 1'b1, rdy);

    // Starvation counter clears when rq2 drops valid; suppression leaves rr alone.
    run_cycle(mk(0, 0, 0, 9'h0, 32'h0, 4'hF, 0, 9'h0, 0, 9'h0, 3'b000, 1, 0, 9'h0, 1, 3'b000, 0, 32'h0), 1'b0, rdy);
    seq_r0 = 8'b0011_1111; seq_r1 = 8'b1000_0000; seq_r2 = 8'b0100_0000;
    for (int k = 0; k < 8; k++) begin
      v = mk(1, 1, (k < 7), 9'h007, $urandom, 4'hF, (k == 7), 9'h003,
             (k != 2 && k < 7), 9'h007, 3'b000, 0, 0, 9'h0, 0, 3'b000, 0, 32'h0);
      run_cycle(v, 1'b0, rdy);
      chk("seq_ready0", 32'(rdy[0]), 32'(seq_r0[k]));
      chk("seq_ready1", 32'(rdy[1]), 32'(seq_r1[k]));
      chk("seq_ready2", 32'(rdy[2]), 32'(seq_r2[k]));
    end

    for (int n = 0; n < 3000; n++) begin
      v = '0;
      v.rstb = ($urandom_range(0, 47) != 0);
      v.v0 = ($urandom_range(0, 2) != 0); v.we0 = 1'($urandom_range(0, 1));
      v.a0 = 9'($urandom_range(0, 7)); v.d0 = $urandom; v.m0 = 4'($urandom_range(0, 15));
      v.v1 = ($urandom_range(0, 2) != 0); v.we1 = 1'($urandom_range(0, 1));
      v.a1 = 9'($urandom_range(0, 7)); v.d1 = $urandom; v.m1 = 4'($urandom_range(0, 15));
      v.v2 = ($urandom_range(0, 2) != 0); v.a2 = 9'($urandom_range(0, 7));
      run_cycle(v, 1'b0, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
